// File: rtl/div_pkg.sv
// Shared types and configuration helpers for the pipelined divider.
package div_pkg;

    localparam int unsigned MIN_WIDTH = 4;

    // Per-transaction qualifiers carried alongside the operands
    typedef struct packed {
        logic quo_neg;
        logic rem_neg;
        logic div0;
        logic ovf;
    } div_flags_t;

    // Request-to-result latency in cycles: entry stage plus one register per iteration stage
    function automatic int unsigned div_latency(input int unsigned width, input int unsigned bps);
        return (bps == 0) ? 0 : (width / bps) + 1;
    endfunction

    // Legal configuration: wide enough, even, and split evenly into stages
    function automatic bit div_cfg_ok(input int unsigned width, input int unsigned bps);
        return (width >= MIN_WIDTH) && ((width % 2) == 0) && (bps != 0) && ((width % bps) == 0);
    endfunction

endpackage

// File: rtl/div_stage.sv
// One iteration stage: BITS_PER_STAGE restoring steps followed by a stage register.
module div_stage
    import div_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter int unsigned TAG_W          = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               prev_valid,
    input  logic [WIDTH:0]     prev_rem,
    input  logic [WIDTH-1:0]   prev_dq,
    input  logic [WIDTH-1:0]   prev_dvs,
    input  div_flags_t         prev_flags,
    input  logic [TAG_W-1:0]   prev_tag,
    output logic               stage_valid,
    output logic [WIDTH:0]     stage_rem,
    output logic [WIDTH-1:0]   stage_dq,
    output logic [WIDTH-1:0]   stage_dvs,
    output div_flags_t         stage_flags,
    output logic [TAG_W-1:0]   stage_tag
);

    // dq holds the unconsumed dividend bits at the top and the quotient bits shifting in at the bottom
    logic [WIDTH:0]   rem_c;
    logic [WIDTH-1:0] dq_c;

    // Restoring steps: shift in next dividend bit, subtract divisor when it fits
    always_comb begin
        rem_c = prev_rem;
        dq_c  = prev_dq;
        for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
            rem_c = {rem_c[WIDTH-1:0], dq_c[WIDTH-1]};
            dq_c  = {dq_c[WIDTH-2:0], 1'b0};
            if (rem_c >= {1'b0, prev_dvs}) begin
                rem_c    = rem_c - {1'b0, prev_dvs};
                dq_c[0]  = 1'b1;
            end
        end
    end

    // Stage register, advanced by the shared pipeline enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_rem   <= '0;
            stage_dq    <= '0;
            stage_dvs   <= '0;
            stage_flags <= '0;
            stage_tag   <= '0;
        end else if (en) begin
            stage_valid <= prev_valid;
            stage_rem   <= rem_c;
            stage_dq    <= dq_c;
            stage_dvs   <= prev_dvs;
            stage_flags <= prev_flags;
            stage_tag   <= prev_tag;
        end
    end

endmodule

// File: rtl/pipe_divider.sv
// Fully pipelined signed/unsigned restoring divider with tag sideband and global-stall flow control.
module pipe_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter int unsigned TAG_W          = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic             signed_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             error_out,
    output logic             overflow_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             busy_out
);

    localparam bit          CFG_OK = div_cfg_ok(WIDTH, BITS_PER_STAGE);
    localparam int unsigned N      = (BITS_PER_STAGE == 0) ? 1 : WIDTH / BITS_PER_STAGE;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Reject unusable configurations at elaboration
    if (!CFG_OK) begin : g_cfg_check
        $fatal(1, "pipe_divider: WIDTH must be >= 4, even, and a multiple of BITS_PER_STAGE");
    end

    // Stage-boundary signals; index 0 is the entry register, index N the final stage
    logic             valid_a [N+1];
    logic [WIDTH:0]   rem_a   [N+1];
    logic [WIDTH-1:0] dq_a    [N+1];
    logic [WIDTH-1:0] dvs_a   [N+1];
    div_flags_t       flags_a [N+1];
    logic [TAG_W-1:0] tag_a   [N+1];

    logic             stall_c;
    logic             advance_c;

    logic             dvd_neg_c;
    logic             dvs_neg_c;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    div_flags_t       flags_c;

    logic             ent_valid;
    logic [WIDTH-1:0] ent_dvd;
    logic [WIDTH-1:0] ent_dvs;
    div_flags_t       ent_flags;
    logic [TAG_W-1:0] ent_tag;

    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;
    logic             busy_c;
    logic             unused_fin;

    // One global stall: a held result freezes every stage
    assign stall_c   = valid_out & ~ready_out;
    assign advance_c = ~stall_c;
    assign ready_in  = advance_c;

    // Entry: operand magnitudes and per-transaction flags
    always_comb begin
        dvd_neg_c       = signed_in & dividend_in[WIDTH-1];
        dvs_neg_c       = signed_in & divisor_in[WIDTH-1];
        dvd_mag_c       = dvd_neg_c ? -dividend_in : dividend_in;
        dvs_mag_c       = dvs_neg_c ? -divisor_in  : divisor_in;
        flags_c         = '0;
        flags_c.quo_neg = dvd_neg_c ^ dvs_neg_c;
        flags_c.rem_neg = dvd_neg_c;
        flags_c.div0    = (divisor_in == '0);
        flags_c.ovf     = signed_in & (dividend_in == MIN_VAL) & (divisor_in == '1);
    end

    // Entry stage register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ent_valid <= 1'b0;
            ent_dvd   <= '0;
            ent_dvs   <= '0;
            ent_flags <= '0;
            ent_tag   <= '0;
        end else if (advance_c) begin
            ent_valid <= valid_in;
            ent_dvd   <= dvd_mag_c;
            ent_dvs   <= dvs_mag_c;
            ent_flags <= flags_c;
            ent_tag   <= tag_in;
        end
    end

    assign valid_a[0] = ent_valid;
    assign rem_a[0]   = '0;
    assign dq_a[0]    = ent_dvd;
    assign dvs_a[0]   = ent_dvs;
    assign flags_a[0] = ent_flags;
    assign tag_a[0]   = ent_tag;

    for (genvar g = 0; g < N; g++) begin : g_stage
        div_stage #(
            .WIDTH          (WIDTH),
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .TAG_W          (TAG_W)
        ) u_stage (
            .clk         (clk_in),
            .rst_n       (rst_n_in),
            .en          (advance_c),
            .prev_valid  (valid_a[g]),
            .prev_rem    (rem_a[g]),
            .prev_dq     (dq_a[g]),
            .prev_dvs    (dvs_a[g]),
            .prev_flags  (flags_a[g]),
            .prev_tag    (tag_a[g]),
            .stage_valid (valid_a[g+1]),
            .stage_rem   (rem_a[g+1]),
            .stage_dq    (dq_a[g+1]),
            .stage_dvs   (dvs_a[g+1]),
            .stage_flags (flags_a[g+1]),
            .stage_tag   (tag_a[g+1])
        );
    end

    // Final remainder is always below the divisor, so its top bit and the divisor are not needed
    assign unused_fin = ^{rem_a[N][WIDTH], dvs_a[N]};

    // Sign fix-up and special-case overrides on the final stage
    always_comb begin
        quo_c = flags_a[N].quo_neg ? -dq_a[N] : dq_a[N];
        rem_c = flags_a[N].rem_neg ? -rem_a[N][WIDTH-1:0] : rem_a[N][WIDTH-1:0];
        if (flags_a[N].div0) begin
            quo_c = '1;
        end else if (flags_a[N].ovf) begin
            quo_c = MIN_VAL;
            rem_c = '0;
        end
    end

    // Occupancy across entry and iteration stages
    always_comb begin
        busy_c = 1'b0;
        for (int unsigned i = 0; i < N + 1; i++) begin
            busy_c = busy_c | valid_a[i];
        end
    end

    assign quotient_out  = quo_c;
    assign remainder_out = rem_c;
    assign tag_out       = tag_a[N];
    assign valid_out     = valid_a[N];
    assign error_out     = valid_a[N] & flags_a[N].div0;
    assign overflow_out  = valid_a[N] & flags_a[N].ovf;
    assign busy_out      = busy_c;

endmodule

// File: tb/tb_pipe_divider.sv
// Directed-vector and scoreboard bench for pipe_divider at WIDTH=8, BITS_PER_STAGE=2.
module tb_pipe_divider;

    localparam int unsigned W   = 8;
    localparam int unsigned BPS = 2;
    localparam int unsigned TW  = 4;
    // Edges after the accepting edge until valid_out rises (total latency 5)
    localparam int EDGES_AFTER_ACCEPT = 4;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [W-1:0]  dividend_in;
    logic [W-1:0]  divisor_in;
    logic          signed_in;
    logic [TW-1:0] tag_in;
    logic          valid_in;
    logic          ready_in;
    logic [W-1:0]  quotient_out;
    logic [W-1:0]  remainder_out;
    logic [TW-1:0] tag_out;
    logic          error_out;
    logic          overflow_out;
    logic          valid_out;
    logic          ready_out;
    logic          busy_out;

    pipe_divider #(
        .WIDTH          (W),
        .BITS_PER_STAGE (BPS),
        .TAG_W          (TW)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .signed_in     (signed_in),
        .tag_in        (tag_in),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .tag_out       (tag_out),
        .error_out     (error_out),
        .overflow_out  (overflow_out),
        .valid_out     (valid_out),
        .ready_out     (ready_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic       sgn;
        logic [3:0] tag;
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic [3:0] tag;
        logic       err;
        logic       ovf;
    } exp_t;

    int   n_applied   = 0;
    int   miscompares = 0;
    int   n_checks    = 0;
    exp_t sb[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] dvd, input logic [7:0] dvs, input logic sgn,
                                input logic [3:0] tag, input logic [7:0] q, input logic [7:0] r,
                                input logic err, input logic ovf);
        vec_t v;
        v.dvd = dvd; v.dvs = dvs; v.sgn = sgn; v.tag = tag;
        v.q = q; v.r = r; v.err = err; v.ovf = ovf;
        return v;
    endfunction

    // Reference behaviour from integer arithmetic
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                                   input logic [3:0] tag);
        exp_t m;
        int   sa;
        int   sb_i;
        m.tag = tag; m.err = 1'b0; m.ovf = 1'b0;
        if (b == 8'h00) begin
            m.q = 8'hFF; m.r = a; m.err = 1'b1;
        end else if (sgn) begin
            sa   = int'($signed(a));
            sb_i = int'($signed(b));
            if (sa == -128 && sb_i == -1) begin
                m.q = 8'h80; m.r = 8'h00; m.ovf = 1'b1;
            end else begin
                m.q = 8'(sa / sb_i);
                m.r = 8'(sa % sb_i);
            end
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    // Single request with an idle pipe: checks latency, payload and flags
    task automatic apply_vec(input vec_t v, input int idx);
        int lat;
        string nm;
        nm = $sformatf("vec%0d", idx);
        dividend_in = v.dvd; divisor_in = v.dvs; signed_in = v.sgn; tag_in = v.tag;
        valid_in = 1'b1; ready_out = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        n_applied++;
        check({nm, "_busy"}, 32'(busy_out), 32'd1);
        lat = 0;
        while (!valid_out && lat < 20) begin
            @(posedge clk_in); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(EDGES_AFTER_ACCEPT));
        check({nm, "_quotient"}, 32'(quotient_out), 32'(v.q));
        check({nm, "_remainder"}, 32'(remainder_out), 32'(v.r));
        check({nm, "_tag"}, 32'(tag_out), 32'(v.tag));
        check({nm, "_error"}, 32'(error_out), 32'(v.err));
        check({nm, "_overflow"}, 32'(overflow_out), 32'(v.ovf));
        @(posedge clk_in); #1;
        check({nm, "_consumed"}, 32'(valid_out), 32'd0);
    endtask

    // Streaming traffic against the scoreboard; rnd=0 is the directed 20-request run with a 3-cycle stall
    task automatic run_stream(input int n_req, input bit rnd, input int budget);
        int   sent;
        int   got;
        int   cyc;
        int   pick;
        exp_t e;
        sent = 0; got = 0; cyc = 0;
        while (got < n_req && cyc < budget) begin
            if (rnd) ready_out = ($urandom_range(0, 3) != 0);
            else     ready_out = !(cyc >= 10 && cyc <= 12);
            if (sent < n_req && (!rnd || $urandom_range(0, 3) != 0)) begin
                valid_in    = 1'b1;
                dividend_in = 8'($urandom);
                tag_in      = 4'(sent);
                if (rnd) begin
                    signed_in = 1'($urandom_range(0, 1));
                    pick = int'($urandom_range(0, 9));
                    if (pick == 0)      divisor_in = 8'h00;
                    else if (pick == 1) divisor_in = 8'hFF;
                    else                divisor_in = 8'($urandom);
                    if ($urandom_range(0, 15) == 0) dividend_in = 8'h80;
                end else begin
                    signed_in  = 1'b0;
                    divisor_in = 8'($urandom_range(1, 255));
                end
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk_in);
            if (!rnd && cyc == 10) begin
                check("stall_valid_out", 32'(valid_out), 32'd1);
                check("stall_ready_in", 32'(ready_in), 32'd0);
            end
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    miscompares++;
                    $display("FAIL unexpected_result: got tag 0x%0h, wanted no result", tag_out);
                end else begin
                    e = sb.pop_front();
                    check("stream_quotient", 32'(quotient_out), 32'(e.q));
                    check("stream_remainder", 32'(remainder_out), 32'(e.r));
                    check("stream_tag", 32'(tag_out), 32'(e.tag));
                    check("stream_error", 32'(error_out), 32'(e.err));
                    check("stream_overflow", 32'(overflow_out), 32'(e.ovf));
                end
                got++;
            end
            if (valid_in && ready_in) begin
                sb.push_back(model(dividend_in, divisor_in, signed_in, tag_in));
                sent++;
                n_applied++;
            end
            @(posedge clk_in); #1;
            cyc++;
        end
        valid_in = 1'b0;
        check("stream_results", 32'(got), 32'(n_req));
        check("stream_leftover", 32'(sb.size()), 32'd0);
    endtask

    initial begin : main
        int waited;
        int stale;

        vecs[0]  = mk(8'd100, 8'd7,  1'b0, 4'h1, 8'd14,  8'd2,  1'b0, 1'b0);
        vecs[1]  = mk(8'hF9,  8'h02, 1'b1, 4'h2, 8'hFD,  8'hFF, 1'b0, 1'b0);
        vecs[2]  = mk(8'h07,  8'hFE, 1'b1, 4'h3, 8'hFD,  8'h01, 1'b0, 1'b0);
        vecs[3]  = mk(8'h2A,  8'h00, 1'b0, 4'h4, 8'hFF,  8'h2A, 1'b1, 1'b0);
        vecs[4]  = mk(8'h2A,  8'h00, 1'b1, 4'h5, 8'hFF,  8'h2A, 1'b1, 1'b0);
        vecs[5]  = mk(8'h80,  8'hFF, 1'b1, 4'h6, 8'h80,  8'h00, 1'b0, 1'b1);
        vecs[6]  = mk(8'h80,  8'hFF, 1'b0, 4'h7, 8'h00,  8'h80, 1'b0, 1'b0);
        vecs[7]  = mk(8'hFF,  8'h01, 1'b0, 4'h8, 8'hFF,  8'h00, 1'b0, 1'b0);
        vecs[8]  = mk(8'h80,  8'h02, 1'b1, 4'h9, 8'hC0,  8'h00, 1'b0, 1'b0);
        vecs[9]  = mk(8'hF0,  8'h00, 1'b1, 4'hA, 8'hFF,  8'hF0, 1'b1, 1'b0);
        vecs[10] = mk(8'd200, 8'd13, 1'b0, 4'hB, 8'd15,  8'd5,  1'b0, 1'b0);
        vecs[11] = mk(8'h81,  8'h7F, 1'b1, 4'hC, 8'hFF,  8'h00, 1'b0, 1'b0);

        rst_n_in = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        dividend_in = '0; divisor_in = '0; signed_in = 1'b0; tag_in = '0;
        #1;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_busy", 32'(busy_out), 32'd0);
        check("reset_ready_in", 32'(ready_in), 32'd1);
        check("reset_quotient", 32'(quotient_out), 32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

        run_stream(20, 1'b0, 200);

        // Reset while three results are queued and the head is stalled
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dividend_in = 8'd100; divisor_in = 8'd7; signed_in = 1'b0; tag_in = 4'(9 + i);
            valid_in = 1'b1;
            @(posedge clk_in); #1;
            n_applied++;
        end
        valid_in = 1'b0;
        waited = 0;
        while (!valid_out && waited < 20) begin
            @(posedge clk_in); #1;
            waited++;
        end
        check("pre_reset_valid_out", 32'(valid_out), 32'd1);
        check("pre_reset_stall_ready_in", 32'(ready_in), 32'd0);
        @(posedge clk_in); #3;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_valid_out", 32'(valid_out), 32'd0);
        check("async_rst_busy", 32'(busy_out), 32'd0);
        check("async_rst_ready_in", 32'(ready_in), 32'd1);
        check("async_rst_quotient", 32'(quotient_out), 32'd0);
        check("async_rst_remainder", 32'(remainder_out), 32'd0);
        check("async_rst_tag", 32'(tag_out), 32'd0);
        check("async_rst_flags", 32'({error_out, overflow_out}), 32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        ready_out = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            if (valid_out) stale++;
        end
        check("post_reset_stale_results", 32'(stale), 32'd0);
        apply_vec(vecs[0], 100);

        run_stream(10000, 1'b1, 60000);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, miscompares);
        $finish;
    end

endmodule
